// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end feeding the decode stage.
// Owns the PC, issues one request at a time on the req/gnt/rvalid port,
// absorbs decode stalls with a one-word skid buffer, and discards
// responses that were made stale by an execute-stage redirect.
// Optional build macro: FETCH_PERF_CNT_EN adds perf_fetched/perf_bubble.
//
// state  | meaning
// -------+-----------------------------------------------------
// S_REQ  | presenting PC on the port, waiting for the grant
// S_WAIT | one fetch in flight, waiting for rvalid
// S_FULL | skid buffer holds a word blocked by stallF
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stallF,
    input  logic        flushD,
    input  logic        pcsrcE,
    input  logic [31:0] pctargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instrD,
    output logic [31:0] pcF,
    output logic [31:0] pcplusfourF,
    output logic        validD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubble
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_inflight;   // address of the outstanding / buffered word
    logic [31:0] skid_instr;
    logic        drop;          // outstanding response is stale
    logic        load_mem;
    logic        load_skid;
    logic [31:0] load_instr;

    // The request is suppressed while reset is held, even though state is S_REQ.
    assign imem_req  = rst_n && (state == S_REQ);
    assign imem_addr = pc;

    // Decide whether the decode slot takes a word this cycle, and from where.
    always_comb begin
        load_mem   = (state == S_WAIT) && imem_rvalid && !drop && !stallF && !pcsrcE;
        load_skid  = (state == S_FULL) && !stallF && !pcsrcE;
        load_instr = load_skid ? skid_instr : imem_rdata;
    end

    // Fetch sequencing: PC, request handshake, drop flag and skid buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            pc_inflight <= '0;
            skid_instr  <= '0;
            drop        <= 1'b0;
        end else if (pcsrcE) begin
            pc <= pctargetE & 32'hFFFF_FFFC;
            case (state)
                S_REQ: begin
                    // memory already accepted this request: wait and drop its reply
                    if (imem_gnt) begin
                        state       <= S_WAIT;
                        drop        <= 1'b1;
                        pc_inflight <= pc;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state <= S_REQ;
                        drop  <= 1'b0;
                    end else begin
                        drop  <= 1'b1;
                    end
                end
                default: state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_gnt) begin
                        state       <= S_WAIT;
                        pc_inflight <= pc;
                        pc          <= pc + 32'd4;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else if (!stallF) begin
                            state <= S_REQ;
                        end else begin
                            skid_instr <= imem_rdata;
                            state      <= S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (!stallF) state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase
        end
    end

    // Decode slot: flush wins over any load; stall simply holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instrD      <= NOP_INSTR;
            pcF         <= '0;
            pcplusfourF <= '0;
            validD      <= 1'b0;
        end else if (flushD) begin
            instrD <= NOP_INSTR;
            validD <= 1'b0;
        end else if (load_mem || load_skid) begin
            instrD      <= load_instr;
            pcF         <= pc_inflight;
            pcplusfourF <= pc_inflight + 32'd4;
            validD      <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Count delivered instructions and unstalled empty decode cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_bubble  <= '0;
        end else begin
            if ((load_mem || load_skid) && !flushD) perf_fetched <= perf_fetched + 32'd1;
            if (!validD && !stallF) perf_bubble <= perf_bubble + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. The stimulus process
// plays instruction memory and hazard unit, steps a transaction-level
// model and queues each instruction expected to reach decode; the monitor
// pops the queue whenever decode presents a new instruction.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stallF = 1'b0, flushD = 1'b0, pcsrcE = 1'b0;
    logic [31:0] pctargetE = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instrD, pcF, pcplusfourF;
    logic        validD;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .stallF(stallF), .flushD(flushD),
        .pcsrcE(pcsrcE), .pctargetE(pctargetE),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instrD(instrD), .pcF(pcF), .pcplusfourF(pcplusfourF), .validD(validD)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } deliv_t;

    deliv_t sb[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    // Transaction-level model: one outstanding fetch, one buffered word,
    // and whether decode currently holds a real instruction.
    logic [31:0] m_pc, m_addr, m_buf_instr, m_buf_pc;
    bit          m_inflight, m_live, m_buf_valid, m_dec_valid;
    logic [15:0] seq = 16'h0100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] next_word();
        logic [31:0] r;
        r   = $urandom;
        seq = seq + 16'd1;
        return {seq, r[15:0]};
    endfunction

    task automatic model_reset();
        m_pc        = RESET_PC;
        m_addr      = '0;
        m_buf_instr = '0;
        m_buf_pc    = '0;
        m_inflight  = 0;
        m_live      = 0;
        m_buf_valid = 0;
        m_dec_valid = 0;
    endtask

    // Effect of one clock edge with the given inputs.
    task automatic model_step(input bit g, input bit rv, input logic [31:0] rd,
                              input bit st, input bit fl, input bit ps,
                              input logic [31:0] tg);
        bit     req_exp, hs, arrive, from_buf, deliver;
        deliv_t d;
        req_exp  = !m_inflight && !m_buf_valid;
        hs       = req_exp && g;
        arrive   = m_inflight && rv;
        from_buf = 0;
        deliver  = 0;
        d.instr  = '0;
        d.pc     = '0;
        if (!ps && !st) begin
            if (m_buf_valid) begin
                deliver = 1; from_buf = 1;
                d.instr = m_buf_instr; d.pc = m_buf_pc;
            end else if (arrive && m_live) begin
                deliver = 1;
                d.instr = rd; d.pc = m_addr;
            end
        end
        if (fl) m_dec_valid = 0;
        else if (deliver) begin
            m_dec_valid = 1;
            sb.push_back(d);
        end
        if (ps || from_buf) m_buf_valid = 0;
        else if (arrive && m_live && st) begin
            m_buf_valid = 1; m_buf_instr = rd; m_buf_pc = m_addr;
        end
        if (arrive) m_inflight = 0;
        else if (ps) m_live = 0;
        if (hs) begin
            m_inflight = 1; m_addr = m_pc; m_live = !ps;
        end
        if (ps) m_pc = {tg[31:2], 2'b00};
        else if (hs) m_pc = m_pc + 32'd4;
    endtask

    // Called at a falling edge: apply inputs for the next rising edge.
    task automatic drive(input bit g, input bit rv, input logic [31:0] rd,
                         input bit st, input bit fl, input bit ps,
                         input logic [31:0] tg);
        imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        stallF = st; flushD = fl; pcsrcE = ps; pctargetE = tg;
        model_step(g, rv, rd, st, fl, ps, tg);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        imem_gnt = 0; imem_rvalid = 0; stallF = 0; flushD = 0; pcsrcE = 0;
        model_reset();
        sb.delete();
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: sample just after each rising edge.
    initial begin : monitor
        logic        pv;
        logic [31:0] pi, pp;
        deliv_t      d;
        pv = 0; pi = '0; pp = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                chk("req_in_reset", imem_req, 0);
                chk("addr_in_reset", imem_addr, RESET_PC);
                chk("validD_in_reset", validD, 0);
                chk("instrD_in_reset", instrD, NOP);
                chk("pcF_in_reset", pcF, 0);
                chk("pcplusfour_in_reset", pcplusfourF, 0);
                pv = 0;
            end else begin
                chk("imem_req", imem_req, !m_inflight && !m_buf_valid);
                chk("imem_addr", imem_addr, m_pc);
                chk("validD", validD, m_dec_valid);
                if (!m_dec_valid) chk("instrD_nop", instrD, NOP);
                if (validD && (!pv || instrD !== pi || pcF !== pp)) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_load: instrD %h pcF %h, none expected", instrD, pcF);
                    end else begin
                        d = sb.pop_front();
                        chk("instrD", instrD, d.instr);
                        chk("pcF", pcF, d.pc);
                        chk("pcplusfourF", pcplusfourF, d.pc + 32'd4);
                    end
                end
                chk("pending_loads", sb.size(), 0);
                pv = validD; pi = instrD; pp = pcF;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit          g, rv, st, fl, ps;
        logic [31:0] tg;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // first fetches from RESET_PC, zero-wait memory
        drive(1, 0, 32'h0, 0, 0, 0, 32'h0);
        drive(0, 1, 32'h00500093, 0, 0, 0, 32'h0);
        drive(1, 0, 32'h0, 0, 0, 0, 32'h0);
        drive(0, 1, next_word(), 0, 0, 0, 32'h0);
        // PC 8 arrives during a 4-cycle stall; grants offered while full
        drive(1, 0, 32'h0, 0, 0, 0, 32'h0);
        drive(0, 1, next_word(), 1, 0, 0, 32'h0);
        repeat (3) drive(1, 0, 32'h0, 1, 0, 0, 32'h0);
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
        // redirect while waiting for PC 12
        drive(1, 0, 32'h0, 0, 0, 0, 32'h0);
        drive(0, 0, 32'h0, 0, 0, 1, 32'h100);
        drive(0, 1, next_word(), 0, 0, 0, 32'h0);
        // redirect in the same cycle as rvalid
        drive(1, 0, 32'h0, 0, 0, 0, 32'h0);
        drive(0, 1, next_word(), 0, 0, 1, 32'h40);
        drive(1, 0, 32'h0, 0, 0, 0, 32'h0);
        drive(0, 1, next_word(), 0, 0, 0, 32'h0);
        // flush together with stall
        drive(0, 0, 32'h0, 1, 1, 0, 32'h0);
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
        // reset while in WAIT, then a late rvalid
        drive(1, 0, 32'h0, 0, 0, 0, 32'h0);
        do_reset(2);
        drive(0, 1, next_word(), 0, 0, 0, 32'h0);
        drive(1, 0, 32'h0, 0, 0, 0, 32'h0);
        drive(0, 1, next_word(), 0, 0, 0, 32'h0);
        // redirect target with low bits set, cancelling a grant
        drive(1, 0, 32'h0, 0, 0, 1, 32'h0000_0203);
        drive(0, 1, next_word(), 0, 0, 0, 32'h0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                g  = ($urandom_range(0, 9) < 7);
                rv = m_inflight && ($urandom_range(0, 9) < 6);
                st = ($urandom_range(0, 99) < 25);
                fl = ($urandom_range(0, 99) < 8);
                ps = ($urandom_range(0, 99) < 6);
                tg = $urandom;
                drive(g, rv, next_word(), st, fl, ps, tg);
            end
        end

        drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end that feeds the decode stage.
- Owns the PC register and drives a request/grant/response instruction-memory port.
- Holds at most one fetch in flight, absorbs decode back-pressure with a one-entry skid buffer, and handles execute-stage redirects by discarding stale responses.
- Outputs instrD, pcF and pcplusfourF, aligned to each other, for the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset
NOP_INSTR, 32'h0000_0013, instruction presented when the decode slot is invalid (addi x0,x0,0)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  reset; asynchronous assert, active-low
stallF  in  1  hazard unit: hold the decode-facing registers, do not accept a new instruction
flushD  in  1  hazard unit: invalidate the decode slot next edge
pcsrcE  in  1  execute-stage redirect strobe (taken branch or jump)
pctargetE  in  32  redirect target
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address; equals the current PC register
imem_gnt  in  1  memory accepts the request this cycle (req & gnt = handshake)
imem_rvalid  in  1  read data valid; at least 1 cycle after the grant
imem_rdata  in  32  instruction word
instrD  out  32  instruction for decode
pcF  out  32  PC of instrD
pcplusfourF  out  32  pcF + 4, modulo 2^32
validD  out  1  instrD is a real instruction

Behaviour:
- Reset (async, rst_n=0):
  - PC = RESET_PC; FSM = REQ.
  - instrD = NOP_INSTR; pcF = 0; pcplusfourF = 0; validD = 0.
  - Skid buffer empty; drop flag = 0; imem_req = 0 while rst_n is low.
  - Reset mid-transaction abandons it; a late rvalid after release with FSM in REQ is ignored.
- FSM states:
  - REQ: imem_req = 1, imem_addr = PC, hold address stable until gnt. On req&gnt: go to WAIT and set PC += 4.
  - WAIT: imem_req = 0; waiting for imem_rvalid.
  - FULL: skid buffer occupied; imem_req = 0.
- Response handling in WAIT (on rvalid):
  - drop flag = 1: discard the word, clear drop, go to REQ.
  - Decode slot can accept (stallF = 0): load instrD/pcF/pcplusfourF with the fetched word and its address, set validD = 1, go to REQ.
  - stallF = 1: write to the skid buffer, go to FULL.
- FULL: on the first cycle with stallF = 0, move the buffer into the decode slot, go to REQ.
- Fetch-to-decode latency: 2 cycles from grant when gnt and rvalid are zero-wait. Sustained throughput is 1 instruction per 2 cycles (single outstanding).
- stallF = 1: instrD, pcF, pcplusfourF and validD hold; PC may still advance for one fetch into the buffer.
- flushD = 1: validD <= 0 and instrD <= NOP_INSTR next edge. pcF is don't-care. Overrides both stallF and an arriving load.
- pcsrcE = 1 (highest priority):
  - PC <= pctargetE.
  - Skid buffer emptied.
  - In WAIT, set drop flag = 1 and stay in WAIT. In REQ or FULL, go to REQ.
  - A grant in the same cycle is cancelled: PC takes pctargetE, and the granted response is dropped via the drop flag.
  - pcsrcE does not itself clear validD; the hazard unit asserts flushD.
- Simultaneous rvalid and pcsrcE in WAIT: the word is discarded and no drop flag is set; FSM goes to REQ with PC = pctargetE.
- pctargetE[1:0] are ignored; forced to 00 in PC.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - Adds outputs perf_fetched (32) and perf_bubble (32); both reset to 0 and wrap at 2^32.
  - perf_fetched increments on each instruction loaded into the decode slot with validD = 1.
  - perf_bubble increments each cycle validD = 0 and stallF = 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then release, gnt = 1, rvalid one cycle after the grant, rdata = 32'h00500093 → imem_addr = 0 first, then 4. After the 1st rvalid: instrD = 32'h00500093, pcF = 0, pcplusfourF = 4, validD = 1.
- stallF held 4 cycles while the response for PC = 8 arrives → decode outputs unchanged, FSM FULL, imem_req = 0. Release stallF → instrD from PC 8 appears next edge with no memory request in between.
- pcsrcE with pctargetE = 32'h100 while in WAIT for PC 12 → the next rvalid word is dropped (validD stays unchanged), then imem_addr = 32'h100.
- pcsrcE and imem_rvalid in the same cycle, target 32'h40 → word discarded, next request address = 32'h40, no extra drop.
- flushD and stallF together → validD = 0, instrD = 32'h00000013.
- rst_n pulsed low in WAIT, late rvalid after release → ignored; first request to RESET_PC.
